ifu_line_fill: RTL and testbench
================================

IFU_LINE_FILL -- requirements
Module: ifu_line_fill

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 Parameter OFFSET_WIDTH, default 4, line offset bits (16-byte line).
REQ-003 Parameter TAG_WIDTH, default ADDR_WIDTH-OFFSET_WIDTH (28), line tag width.
REQ-004 Parameter LINE_WIDTH, default 128, instruction line width.
REQ-005 Parameter WORD_WIDTH, default 32, memory beat width; BEATS = LINE_WIDTH/WORD_WIDTH (4).
REQ-006 Clock  in  1  single clock; all state updates on its rising edge.
REQ-007 Rst  in  1  asynchronous, active-high reset.
REQ-008 cache_reqTagIn  in  TAG_WIDTH  miss tag from ifu_cache (mem_reqTagOut).
REQ-009 cache_reqTagValidIn  in  1  miss tag valid (mem_reqTagValidOut).
REQ-010 mem_reqAddrOut  out  ADDR_WIDTH  line-aligned read address {tag, OFFSET_WIDTH'b0}.
REQ-011 mem_reqValidOut  out  1  memory read request valid.
REQ-012 mem_reqReadyIn  in  1  memory accepts request.
REQ-013 mem_rspDataIn  in  WORD_WIDTH  read beat data, lowest word first.
REQ-014 mem_rspValidIn  in  1  beat valid.
REQ-015 cache_rspTagOut  out  TAG_WIDTH  filled line tag (to ifu_cache mem_rspTagIn).
REQ-016 cache_rspInsLineOut  out  LINE_WIDTH  assembled line (to mem_rspInsLineIn).
REQ-017 cache_rspInsLineValidOut  out  1  one-cycle fill pulse (to mem_rspInsLineValidIn).
REQ-018 fill_busyOut  out  1  high when state != IDLE or pending slot occupied.
REQ-019 dropCntOut  out  8  saturating count of dropped miss requests.

Function
REQ-020 FSM states IDLE, REQ, RECV, RESP; one fill outstanding at a time.
REQ-021 IDLE: pending valid -> load pending tag as current, clear pending, go REQ; else cache_reqTagValidIn -> latch tag as current, go REQ.
REQ-022 REQ: mem_reqValidOut=1, mem_reqAddrOut={current tag, 0}, both held stable until mem_reqValidOut && mem_reqReadyIn; then go RECV, beat counter=0.
REQ-023 RECV: each cycle with mem_rspValidIn writes mem_rspDataIn into line bits [beat*WORD_WIDTH +: WORD_WIDTH], beat++; on beat BEATS-1 go RESP.
REQ-024 RECV: cycles without mem_rspValidIn hold state and counter; no timeout.
REQ-025 RESP: cache_rspInsLineValidOut=1 for exactly one cycle with cache_rspTagOut=current tag and full line; next state IDLE.
REQ-026 cache_rspTagOut/cache_rspInsLineOut hold last filled values outside RESP; valid low outside RESP.
REQ-027 mem_rspValidIn outside RECV ignored; no line update.
REQ-028 Minimum latency: tag sampled at edge T, REQ in cycle T+1, ready high -> RECV T+2, beats T+2..T+5, fill pulse in cycle T+6.
REQ-029 Pending slot (1 entry): while state != IDLE, a valid tag differing from current tag and pending tag is stored if slot empty.
REQ-030 Tag equal to current tag (state != IDLE) or to valid pending tag: discarded silently, dropCntOut unchanged.
REQ-031 New distinct tag with pending slot full: dropped, dropCntOut += 1, saturates at 255.
REQ-032 IDLE with pending valid and new tag same cycle: pending moves to current; new tag enters pending unless equal to the moving tag (then discarded).
REQ-033 Tag arriving in RESP cycle with same tag as current: discarded (line is being delivered).

Reset
REQ-034 Rst high asynchronously forces IDLE, beat counter 0, pending invalid, current tag 0, line register 0, dropCntOut 0.
REQ-035 During reset all outputs 0: mem_reqValidOut, mem_reqAddrOut, cache_rspInsLineValidOut, cache_rspTagOut, cache_rspInsLineOut, fill_busyOut.
REQ-036 Reset mid-fill abandons the fill; no fill pulse issued; partially received beats discarded.

Verification
REQ-037 Basic fill: tag 0x0000100, ready=1, beats 0x11111111,0x22222222,0x33333333,0x44444444 -> mem_reqAddrOut=0x00001000, pulse at T+6, line=0x44444444333333332222222211111111.
REQ-038 Backpressure: mem_reqReadyIn low 3 cycles, one idle gap between beats -> address/valid stable while waiting, single pulse, correct line, fill_busyOut high throughout.
REQ-039 Pending: tag 0x0000100 then 0x0000200 during RECV -> two fills in order, second request 0x00002000 issued after first pulse, dropCntOut=0.
REQ-040 Drop: during fill of A, send B, C, C, A -> B pending, C dropped twice (dropCntOut=2), A discarded; only A then B filled.
REQ-041 Saturation: 300 distinct drops with slot full -> dropCntOut=255.
REQ-042 Reset mid-RECV after 2 beats -> all outputs 0, no pulse; next tag yields clean fill matching REQ-037 timing.

Source files
------------

// File: rtl/ifu_line_fill.sv
// ifu_line_fill: fetches one instruction line from memory per I-cache miss.
// A single fill is outstanding at a time. One further miss tag can wait in a
// one-entry pending slot. Distinct misses that arrive while the slot is full
// are dropped, and a saturating counter records them.
//
// Handshake: the memory request is transferred on any rising edge where
// mem_reqValidOut && mem_reqReadyIn. While it waits, mem_reqValidOut and
// mem_reqAddrOut stay stable. Response beats have no back-pressure. A beat
// is consumed on every RECV cycle with mem_rspValidIn high, lowest word first.
// The fill result is a one-cycle pulse with no ready input.
module ifu_line_fill #(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 4,
    parameter int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH,
    parameter int LINE_WIDTH   = 128,
    parameter int WORD_WIDTH   = 32
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic [TAG_WIDTH-1:0]  cache_reqTagIn,
    input  logic                  cache_reqTagValidIn,
    output logic [ADDR_WIDTH-1:0] mem_reqAddrOut,
    output logic                  mem_reqValidOut,
    input  logic                  mem_reqReadyIn,
    input  logic [WORD_WIDTH-1:0] mem_rspDataIn,
    input  logic                  mem_rspValidIn,
    output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
    output logic [LINE_WIDTH-1:0] cache_rspInsLineOut,
    output logic                  cache_rspInsLineValidOut,
    output logic                  fill_busyOut,
    output logic [7:0]            dropCntOut,
    output logic [1:0]            state_dbg
);
    localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RECV = 2'd2, RESP = 2'd3} state_t;

    state_t                state, state_next;
    logic [TAG_WIDTH-1:0]  cur_tag, pend_tag, rsp_tag_q;
    logic                  pend_valid;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [LINE_WIDTH-1:0] line_q, line_merged, rsp_line_q;
    logic [7:0]            drop_cnt;
    logic                  beat_fire, last_beat, tag_dup;

    assign beat_fire = (state == RECV) && mem_rspValidIn;
    assign last_beat = beat_fire && (beat_cnt == BEAT_W'(BEATS - 1));
    // A miss for the line being fetched, or for the one already queued, needs no new fill.
    assign tag_dup   = (cache_reqTagIn == cur_tag) || (pend_valid && (cache_reqTagIn == pend_tag));

    assign mem_reqAddrOut      = {cur_tag, {OFFSET_WIDTH{1'b0}}};
    assign cache_rspTagOut     = rsp_tag_q;
    assign cache_rspInsLineOut = rsp_line_q;
    assign dropCntOut          = drop_cnt;
    assign state_dbg           = state;

    // State register.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: a queued miss takes priority over a new one when starting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pend_valid || cache_reqTagValidIn) state_next = REQ;
            REQ:     if (mem_reqReadyIn) state_next = RECV;
            RECV:    if (last_beat) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state and the pending slot.
    always_comb begin
        mem_reqValidOut          = (state == REQ);
        cache_rspInsLineValidOut = (state == RESP);
        fill_busyOut             = (state != IDLE) || pend_valid;
    end

    // Merge the incoming beat into its word slot of the line being assembled.
    always_comb begin
        line_merged = line_q;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == BEAT_W'(b)) line_merged[b*WORD_WIDTH +: WORD_WIDTH] = mem_rspDataIn;
        end
    end

    // Miss tag bookkeeping: current tag, one-entry pending slot, drop counter.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            cur_tag    <= '0;
            pend_tag   <= '0;
            pend_valid <= 1'b0;
            drop_cnt   <= 8'd0;
        end else if (state == IDLE) begin
            if (pend_valid) begin
                cur_tag <= pend_tag;
                // The queued tag moves to current; a new distinct tag refills the slot.
                if (cache_reqTagValidIn && (cache_reqTagIn != pend_tag)) pend_tag <= cache_reqTagIn;
                else                                                     pend_valid <= 1'b0;
            end else if (cache_reqTagValidIn) begin
                cur_tag <= cache_reqTagIn;
            end
        end else if (cache_reqTagValidIn && !tag_dup) begin
            if (!pend_valid) begin
                pend_tag   <= cache_reqTagIn;
                pend_valid <= 1'b1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Beat counting, line assembly and capture of the delivered line.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            beat_cnt   <= '0;
            line_q     <= '0;
            rsp_tag_q  <= '0;
            rsp_line_q <= '0;
        end else begin
            if ((state == REQ) && mem_reqReadyIn) begin
                beat_cnt <= '0;
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
                line_q   <= line_merged;
            end
            if (last_beat) begin
                rsp_tag_q  <= cur_tag;
                rsp_line_q <= line_merged;
            end
        end
    end
endmodule

// File: tb/tb_ifu_line_fill.sv
// Testbench for ifu_line_fill. A transaction-level model predicts which lines
// get filled, in what order, and when. A monitor checks every fill pulse
// against the expected queue.
module tb_ifu_line_fill;
    localparam int TW = 28;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int WW = 32;

    logic          clk, rst;
    logic [TW-1:0] tag_in;
    logic          tag_valid;
    logic [AW-1:0] req_addr;
    logic          req_valid, req_ready;
    logic [WW-1:0] rsp_data;
    logic          rsp_valid;
    logic [TW-1:0] fill_tag;
    logic [LW-1:0] fill_line;
    logic          fill_valid, busy;
    logic [7:0]    drop_cnt;
    logic [1:0]    state_dbg;

    ifu_line_fill dut (
        .Clock                    (clk),
        .Rst                      (rst),
        .cache_reqTagIn           (tag_in),
        .cache_reqTagValidIn      (tag_valid),
        .mem_reqAddrOut           (req_addr),
        .mem_reqValidOut          (req_valid),
        .mem_reqReadyIn           (req_ready),
        .mem_rspDataIn            (rsp_data),
        .mem_rspValidIn           (rsp_valid),
        .cache_rspTagOut          (fill_tag),
        .cache_rspInsLineOut      (fill_line),
        .cache_rspInsLineValidOut (fill_valid),
        .fill_busyOut             (busy),
        .dropCntOut               (drop_cnt),
        .state_dbg                (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [TW-1:0] exp_tag_q[$];
    logic [LW-1:0] exp_line_q[$];
    int            exp_cyc_q[$];
    logic [TW-1:0] last_tag  = '0;
    logic [LW-1:0] last_line = '0;

    // ---------------- reference model ----------------
    // m_fill: 0 no fill, 1 awaiting request acceptance, 2 collecting beats,
    // 3 delivering the line this cycle.
    int            m_fill  = 0;
    int            m_beats = 0;
    int            m_drops = 0;
    logic [TW-1:0] m_cur   = '0;
    logic [TW-1:0] m_pend_q[$];
    logic [LW-1:0] m_line  = '0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One clock cycle: check the visible state, drive inputs, advance the model.
    task automatic step(input logic tv, input logic [TW-1:0] tag, input logic rdy,
                        input logic rv, input logic [WW-1:0] d);
        logic start;
        check("req_valid", req_valid, m_fill == 1);
        if (m_fill == 1) check("req_addr", req_addr, {m_cur, 4'h0});
        check("busy", busy, (m_fill != 0) || (m_pend_q.size() != 0));
        check("drop_cnt", drop_cnt, m_drops);
        tag_valid = tv;
        tag_in    = tag;
        req_ready = rdy;
        rsp_valid = rv;
        rsp_data  = d;
        start = 1'b0;
        if (m_fill == 0) begin
            if (m_pend_q.size() != 0) begin
                m_cur = m_pend_q.pop_front();
                start = 1'b1;
                if (tv && (tag != m_cur)) m_pend_q.push_back(tag);
            end else if (tv) begin
                m_cur = tag;
                start = 1'b1;
            end
        end else if (tv) begin
            if (!((tag == m_cur) || (m_pend_q.size() != 0 && m_pend_q[0] == tag))) begin
                if (m_pend_q.size() == 0) m_pend_q.push_back(tag);
                else if (m_drops < 255)   m_drops++;
            end
        end
        case (m_fill)
            0: if (start) m_fill = 1;
            1: if (rdy) begin m_fill = 2; m_beats = 0; end
            2: if (rv) begin
                   m_line[m_beats*WW +: WW] = d;
                   m_beats++;
                   if (m_beats == LW / WW) begin
                       m_fill = 3;
                       exp_tag_q.push_back(m_cur);
                       exp_line_q.push_back(m_line);
                       exp_cyc_q.push_back(cyc + 1);
                   end
               end
            default: m_fill = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    // Let outstanding and queued fills complete with an always-ready memory.
    task automatic drain();
        int guard;
        guard = 0;
        while ((m_fill != 0 || m_pend_q.size() != 0) && guard < 200) begin
            step(1'b0, '0, 1'b1, 1'b1, $urandom);
            guard++;
        end
        check("drain_bound", guard < 200, 1'b1);
        idle_steps(2);
    endtask

    // Asserted mid-cycle, away from the clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_req_addr", req_addr, 32'h0);
        check("rst_fill_valid", fill_valid, 1'b0);
        check("rst_fill_tag", fill_tag, 28'h0);
        check("rst_fill_line", fill_line, 128'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_drop_cnt", drop_cnt, 8'h0);
        check("rst_state", state_dbg, 2'd0);
        m_fill = 0; m_beats = 0; m_drops = 0; m_cur = '0; m_line = '0;
        m_pend_q.delete();
        last_tag = '0; last_line = '0;
        tag_valid = 1'b0; tag_in = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Fixed fill: tag 0x100 with four known beats and an always-ready memory.
    task automatic basic_fill();
        step(1'b1, 28'h0000100, 1'b1, 1'b0, '0);
        check("basic_addr", req_addr, 32'h00001000);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b1, 32'h11111111);
        step(1'b0, '0, 1'b1, 1'b1, 32'h22222222);
        step(1'b0, '0, 1'b1, 1'b1, 32'h33333333);
        step(1'b0, '0, 1'b1, 1'b1, 32'h44444444);
        drain();
        check("basic_line", fill_line, 128'h44444444333333332222222211111111);
        check("basic_tag", fill_tag, 28'h0000100);
    endtask

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        if (fill_valid) begin
            if (exp_tag_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got pulse tag 0x%0h expected none", fill_tag);
            end else begin
                logic [TW-1:0] et;
                logic [LW-1:0] el;
                int            ec;
                et = exp_tag_q.pop_front();
                el = exp_line_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("fill_tag", fill_tag, et);
                check("fill_line", fill_line, el);
                check("fill_cycle", cyc, ec);
                last_tag  = et;
                last_line = el;
            end
        end else begin
            check("hold_tag", fill_tag, last_tag);
            check("hold_line", fill_line, last_line);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        tag_valid = 1'b0; tag_in = '0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        @(negedge clk);
        do_reset();

        // Basic fill with exact latency.
        basic_fill();

        // Request back-pressure and a gap between beats; stray beats outside RECV.
        step(1'b1, 28'h0000ABC, 1'b0, 1'b1, 32'hDEADBEEF);
        step(1'b0, '0, 1'b0, 1'b1, 32'hBADBAD00);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        check("bp_addr_stable", req_addr, 32'h0000ABC0);
        step(1'b0, '0, 1'b0, 1'b1, 32'hBADBAD01);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 32'hA0A0A0A0);
        step(1'b0, '0, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b1, 32'hB1B1B1B1);
        step(1'b0, '0, 1'b0, 1'b1, 32'hC2C2C2C2);
        step(1'b0, '0, 1'b0, 1'b1, 32'hD3D3D3D3);
        drain();
        check("bp_line", fill_line, 128'hD3D3D3D3C2C2C2C2B1B1B1B1A0A0A0A0);

        // Second miss arrives during RECV and is queued.
        step(1'b1, 28'h0000100, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b1, $urandom);
        step(1'b1, 28'h0000200, 1'b1, 1'b1, $urandom);
        drain();
        check("pend_drops", drop_cnt, 8'd0);
        check("pend_last_tag", fill_tag, 28'h0000200);

        // B queued, C dropped twice, A discarded.
        do_reset();
        step(1'b1, 28'h00000A0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b1, 28'h00000B0, 1'b1, 1'b1, $urandom);
        step(1'b1, 28'h00000C0, 1'b1, 1'b1, $urandom);
        step(1'b1, 28'h00000C0, 1'b1, 1'b0, '0);
        step(1'b1, 28'h00000A0, 1'b1, 1'b1, $urandom);
        drain();
        check("drop_two", drop_cnt, 8'd2);
        check("drop_last_tag", fill_tag, 28'h00000B0);

        // Drop counter saturation while the request is held off.
        do_reset();
        step(1'b1, 28'h0000010, 1'b0, 1'b0, '0);
        step(1'b1, 28'h0000020, 1'b0, 1'b0, '0);
        for (int i = 0; i < 300; i++) step(1'b1, 28'h0001000 + 28'(i), 1'b0, 1'b0, '0);
        check("drop_saturate", drop_cnt, 8'd255);
        drain();

        // Reset in the middle of RECV, then a clean fill.
        do_reset();
        step(1'b1, 28'h0000300, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b1, 32'h55555555);
        step(1'b0, '0, 1'b1, 1'b1, 32'h66666666);
        do_reset();
        idle_steps(2);
        basic_fill();

        // Randomized traffic over a small tag set to provoke collisions.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 30, 28'($urandom_range(1, 6)),
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, $urandom);
        end
        drain();
        check("exp_queue_empty", exp_tag_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
